ram_arbiter: RTL and testbench

Two-port request/acknowledge arbiter that shares one single-port RAM16K-style memory between two requesters, e.g. CPU data port (port 0) and a DMA/screen-refresh engine (port 1). Sits directly in front of the memory: it owns the memory's `in`, `load` and `address` pins, consumes its combinational `out`, and serialises accesses as one read or one write per grant.

---
 rtl/ram_arb_if.sv | 34 +++
 rtl/ram_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_if.sv
// Bundle of requester handshakes and RAM16K-style memory pins shared by ram_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface ram_arb_if #(
    parameter int AW = 14,
    parameter int DW = 16
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] ram_in;
    logic          ram_load;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_out;
    logic          busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
        output ack0, ack1, rdata0, rdata1, ram_in, ram_load, ram_address, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
        input  ack0, ack1, rdata0, rdata1, ram_in, ram_load, ram_address, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM: IDLE -> ACCESS -> DONE per grant.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention, no pointer register).
module ram_arbiter #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    ram_arb_if.slave    bus_io
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q;
    logic          cmd_we_q;
    logic          cmd_id_q;
    logic [AW-1:0] cmd_addr_q;
    logic [DW-1:0] cmd_wdata_q;
    logic          ack0_q;
    logic          ack1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          grant_d;
    logic          cmd_we_d;
    logic [AW-1:0] cmd_addr_d;
    logic [DW-1:0] cmd_wdata_d;

`ifndef RAM_ARB_FIXED_PRIO_EN
    // 0 = port 0 favoured on the next simultaneous request, 1 = port 1 favoured
    logic          ptr_q;
`endif

    // Pick the winner among live requests and mux its command fields
    always_comb begin
        grant_d     = 1'b0;
        cmd_we_d    = bus_io.we0;
        cmd_addr_d  = bus_io.addr0;
        cmd_wdata_d = bus_io.wdata0;
        if (bus_io.req0 && bus_io.req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            grant_d = 1'b0;
`else
            grant_d = ptr_q;
`endif
        end else if (bus_io.req1) begin
            grant_d = 1'b1;
        end else begin
            grant_d = 1'b0;
        end
        if (grant_d) begin
            cmd_we_d    = bus_io.we1;
            cmd_addr_d  = bus_io.addr1;
            cmd_wdata_d = bus_io.wdata1;
        end else begin
            cmd_we_d    = bus_io.we0;
            cmd_addr_d  = bus_io.addr0;
            cmd_wdata_d = bus_io.wdata0;
        end
    end

    // Access sequencer: latch command, perform the memory cycle, pulse the ack
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_we_q    <= 1'b0;
            cmd_id_q    <= 1'b0;
            cmd_addr_q  <= {AW{1'b0}};
            cmd_wdata_q <= {DW{1'b0}};
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= {DW{1'b0}};
            rdata1_q    <= {DW{1'b0}};
`ifndef RAM_ARB_FIXED_PRIO_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    if (bus_io.req0 || bus_io.req1) begin
                        state_q     <= ACCESS;
                        cmd_id_q    <= grant_d;
                        cmd_we_q    <= cmd_we_d;
                        cmd_addr_q  <= cmd_addr_d;
                        cmd_wdata_q <= cmd_wdata_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    state_q <= DONE;
                    ack0_q  <= ~cmd_id_q;
                    ack1_q  <= cmd_id_q;
                    // The memory output is combinational, so the read completes on this edge
                    if (!cmd_we_q) begin
                        if (cmd_id_q) begin
                            rdata1_q <= bus_io.ram_out;
                        end else begin
                            rdata0_q <= bus_io.ram_out;
                        end
                    end else begin
                        rdata0_q <= rdata0_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
                    ptr_q   <= ~cmd_id_q;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                end
            endcase
        end
    end

    // Write enable depends only on state and latched command, never on live inputs
    assign bus_io.ram_load    = (state_q == ACCESS) && cmd_we_q;
    assign bus_io.ram_address = cmd_addr_q;
    assign bus_io.ram_in      = cmd_wdata_q;
    assign bus_io.ack0        = ack0_q;
    assign bus_io.ack1        = ack1_q;
    assign bus_io.rdata0      = rdata0_q;
    assign bus_io.rdata1      = rdata1_q;
    assign bus_io.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant choice, memory contents, per-port read data).
module tb_ram_arbiter;
    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic fill = 1'b1;

    int errors = 0;
    int checks = 0;

    ram_arb_if #(.AW(AW), .DW(DW)) bus ();

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        return 16'(i) ^ 16'hA5A5;
    endfunction

    // Behavioural RAM16K: combinational read, write on rising edge
    logic [DW-1:0] ram [0:DEPTH-1];
    assign bus.ram_out = ram[bus.ram_address];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
        end else if (bus.ram_load) begin
            ram[bus.ram_address] <= bus.ram_in;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] exp_rd  [2];
    int            last_served;

    // Requester command registers
    logic          p_req   [2];
    logic          p_we    [2];
    logic [AW-1:0] p_addr  [2];
    logic [DW-1:0] p_wdata [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        bus.req0   = p_req[0];
        bus.req1   = p_req[1];
        bus.we0    = p_we[0];
        bus.we1    = p_we[1];
        bus.addr0  = p_addr[0];
        bus.addr1  = p_addr[1];
        bus.wdata0 = p_wdata[0];
        bus.wdata1 = p_wdata[1];
    endtask

    task automatic model_reset();
        last_served = 1;
        exp_rd[0]   = '0;
        exp_rd[1]   = '0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_busy"},   32'(bus.busy),     32'd0);
        chk({tag, "_ack0"},   32'(bus.ack0),     32'd0);
        chk({tag, "_ack1"},   32'(bus.ack1),     32'd0);
        chk({tag, "_load"},   32'(bus.ram_load), 32'd0);
        chk({tag, "_rdata0"}, 32'(bus.rdata0),   32'(exp_rd[0]));
        chk({tag, "_rdata1"}, 32'(bus.rdata1),   32'(exp_rd[1]));
    endtask

    // Entered at an IDLE-cycle negedge with requests driven; returns at the ack-cycle negedge
    task automatic serve(input string tag, output int w);
        if (p_req[0] && p_req[1]) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = (last_served == 0) ? 1 : 0;
`endif
        end else begin
            w = p_req[1] ? 1 : 0;
        end
        @(negedge clk);
        chk({tag, "_acc_busy"}, 32'(bus.busy),        32'd1);
        chk({tag, "_acc_load"}, 32'(bus.ram_load),    32'(p_we[w]));
        chk({tag, "_acc_addr"}, 32'(bus.ram_address), 32'(p_addr[w]));
        chk({tag, "_acc_in"},   32'(bus.ram_in),      32'(p_wdata[w]));
        chk({tag, "_acc_acks"}, 32'({bus.ack1, bus.ack0}), 32'd0);
        @(negedge clk);
        if (p_we[w]) ref_mem[p_addr[w]] = p_wdata[w];
        else         exp_rd[w] = ref_mem[p_addr[w]];
        last_served = w;
        chk({tag, "_ack0"},   32'(bus.ack0),     32'(w == 0));
        chk({tag, "_ack1"},   32'(bus.ack1),     32'(w == 1));
        chk({tag, "_dload"},  32'(bus.ram_load), 32'd0);
        chk({tag, "_dbusy"},  32'(bus.busy),     32'd1);
        chk({tag, "_rdata0"}, 32'(bus.rdata0),   32'(exp_rd[0]));
        chk({tag, "_rdata1"}, 32'(bus.rdata1),   32'(exp_rd[1]));
    endtask

    task automatic single(input string tag, input int p, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int w;
        p_req[p]   = 1'b1;
        p_we[p]    = we;
        p_addr[p]  = addr;
        p_wdata[p] = wdata;
        drive();
        serve(tag, w);
        idle_check({tag, "_idle"});
        p_req[p] = 1'b0;
        drive();
    endtask

    initial begin
        int w;
        int mask;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
        end
        drive();
        model_reset();

        // Reset values
        @(negedge clk);
        chk("rst_ack0",  32'(bus.ack0),        32'd0);
        chk("rst_ack1",  32'(bus.ack1),        32'd0);
        chk("rst_rd0",   32'(bus.rdata0),      32'd0);
        chk("rst_rd1",   32'(bus.rdata1),      32'd0);
        chk("rst_busy",  32'(bus.busy),        32'd0);
        chk("rst_load",  32'(bus.ram_load),    32'd0);
        chk("rst_addr",  32'(bus.ram_address), 32'd0);
        chk("rst_in",    32'(bus.ram_in),      32'd0);
        fill = 1'b0;
        rst  = 1'b0;

        // Single write, then read back on the other port
        single("wr0", 0, 1'b1, 14'h0005, 16'h1234);
        single("rd1", 1, 1'b0, 14'h0005, 16'h0000);
        idle_check("rd1_hold");

        // Contention from reset: both write their id to 0x3FFF continuously
        p_req[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 14'h3FFF; p_wdata[0] = 16'h0000;
        p_req[1] = 1'b1; p_we[1] = 1'b1; p_addr[1] = 14'h3FFF; p_wdata[1] = 16'h0001;
        drive();
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            serve("cont", w);
            idle_check("cont_idle");
        end
        chk("cont_mem", 32'(ram[14'h3FFF]), 32'(w));
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        drive();

        // Reset during a write access
        single("old", 0, 1'b1, 14'h0100, 16'h5555);
        p_req[1] = 1'b1; p_we[1] = 1'b1; p_addr[1] = 14'h0100; p_wdata[1] = 16'hBEEF;
        drive();
        @(negedge clk);
        chk("mid_load_pre", 32'(bus.ram_load), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_load_drop", 32'(bus.ram_load), 32'd0);
        chk("mid_busy",      32'(bus.busy),     32'd0);
        p_req[1] = 1'b0;
        drive();
        @(negedge clk);
        chk("mid_ack1", 32'(bus.ack1), 32'd0);
        model_reset();
        rst = 1'b0;
        idle_check("mid_after");
        chk("mid_mem", 32'(ram[14'h0100]), 32'h5555);
        single("mid_rd", 0, 1'b0, 14'h0100, 16'h0000);

        // Wrap and hold
        single("wrap0", 0, 1'b0, 14'h3FFF, 16'h0000);
        single("wrap1", 1, 1'b0, 14'h0000, 16'h0000);

        // Random traffic
        for (int it = 0; it < 30; it++) begin
            mask = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                if (mask[p]) begin
                    p_req[p]   = 1'b1;
                    p_we[p]    = 1'($urandom_range(0, 1));
                    p_addr[p]  = ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom_range(0, 7));
                    p_wdata[p] = 16'($urandom);
                end
            end
            drive();
            serve("rnd", w);
            idle_check("rnd_idle");
            p_req[w] = 1'b0;
            drive();
            if (p_req[1 - w]) begin
                serve("rnd2", w);
                idle_check("rnd2_idle");
                p_req[w] = 1'b0;
                drive();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
